// File: rtl/sp_ram_arb_pkg.sv
// rtl/sp_ram_arb_pkg.sv - shared state encoding and master indices for sp_ram_arbiter
package sp_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RD_CAP = 2'd3
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with a one-bit last-grant pointer
module rr_arbiter2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = req;
        // Under contention the master that did not win last time gets the grant.
        if (req == 2'b11) begin
            gnt = (last_q == M1) ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - shares one single-port sync RAM between two request/response masters
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_e                state_q, state_d;
    logic                  idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic [1:0] gnt;
    logic       idle;
    logic       sel;

    assign idle = (state_q == IDLE);
    assign sel  = gnt[1];

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({m1_req_valid, m0_req_valid}),
        .advance (idle),
        .gnt     (gnt)
    );

    // Ready is forced low while reset is held so nothing handshakes into a resetting FSM.
    assign m0_req_ready = rst_n & idle & gnt[0];
    assign m1_req_ready = rst_n & idle & gnt[1];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cs_d        = cs_q;
        we_d        = we_q;
        oe_d        = oe_q;
        rsp_valid_d = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    idx_d   = sel;
                    addr_d  = sel ? m1_req_addr : m0_req_addr;
                    wdata_d = sel ? m1_req_wdata : m0_req_wdata;
                    we_d    = sel ? m1_req_we : m0_req_we;
                    oe_d    = ~we_d;
                    cs_d    = 1'b1;
                    state_d = we_d ? WR : RD;
                end
            end
            WR: begin
                rsp_valid_d[idx_q] = 1'b1;
                cs_d    = 1'b0;
                we_d    = 1'b0;
                oe_d    = 1'b0;
                addr_d  = '0;
                state_d = IDLE;
            end
            RD: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rsp_valid_d[idx_q] = 1'b1;
                if (idx_q == M0) begin
                    rdata0_d = ram_data;
                end else begin
                    rdata1_d = ram_data;
                end
                cs_d    = 1'b0;
                oe_d    = 1'b0;
                addr_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= M0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ram_cs       = cs_q;
    assign ram_we       = we_q;
    assign ram_oe       = oe_q;
    assign ram_addr     = addr_q;
    assign ram_data     = we_q ? wdata_q : 'z;
    assign m0_rsp_valid = rsp_valid_q[0];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m0_rsp_rdata = rdata0_q;
    assign m1_rsp_rdata = rdata1_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - scoreboard bench for sp_ram_arbiter with a behavioural sync RAM
module tb_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
    logic [3:0]  m0_req_addr;
    logic [15:0] m0_req_wdata, m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
    logic [3:0]  m1_req_addr;
    logic [15:0] m1_req_wdata, m1_rsp_rdata;
    logic        ram_cs, ram_we, ram_oe;
    logic [3:0]  ram_addr;
    wire  [15:0] ram_data;

    sp_ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_oe       (ram_oe),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data)
    );

    always #5 clk = ~clk;

    // Behavioural single_port_sync_ram.
    logic [15:0] mem [16];
    logic [15:0] ram_rd_q;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && ram_oe && !ram_we) ram_rd_q <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : 'z;

    typedef struct {
        bit          rd;
        logic [15:0] data;
        int          hs;
    } exp_t;

    exp_t        q0[$], q1[$];
    int          glog_m[$], glog_e[$];
    logic [15:0] shadow [16];
    logic [15:0] swv [16];
    logic [15:0] last0, last1;
    int          cyc = 0;
    int          nvec = 0, nerr = 0;
    int          rcnt0 = 0, rcnt1 = 0;
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: responses are checked against the scoreboard, handshakes feed it.
    always @(negedge clk) begin
        #2;
        if (m0_rsp_valid) begin
            rcnt0++;
            if (q0.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL m0_unexpected_rsp: rsp_valid=1 required 0 (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                chk("m0_rsp_latency", cyc - e.hs, e.rd ? 2 : 1);
                if (e.rd) begin
                    chk("m0_rdata", {16'h0, m0_rsp_rdata}, {16'h0, e.data});
                    last0 = e.data;
                end else begin
                    chk("m0_wr_rdata_hold", {16'h0, m0_rsp_rdata}, {16'h0, last0});
                end
            end
        end
        if (m1_rsp_valid) begin
            rcnt1++;
            if (q1.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL m1_unexpected_rsp: rsp_valid=1 required 0 (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                chk("m1_rsp_latency", cyc - e.hs, e.rd ? 2 : 1);
                if (e.rd) begin
                    chk("m1_rdata", {16'h0, m1_rsp_rdata}, {16'h0, e.data});
                    last1 = e.data;
                end else begin
                    chk("m1_wr_rdata_hold", {16'h0, m1_rsp_rdata}, {16'h0, last1});
                end
            end
        end
        if (m0_req_valid && m0_req_ready) begin
            if (m0_req_we) shadow[m0_req_addr] = m0_req_wdata;
            e.rd = !m0_req_we; e.data = shadow[m0_req_addr]; e.hs = cyc + 1;
            q0.push_back(e);
            glog_m.push_back(0); glog_e.push_back(cyc + 1);
        end
        if (m1_req_valid && m1_req_ready) begin
            if (m1_req_we) shadow[m1_req_addr] = m1_req_wdata;
            e.rd = !m1_req_we; e.data = shadow[m1_req_addr]; e.hs = cyc + 1;
            q1.push_back(e);
            glog_m.push_back(1); glog_e.push_back(cyc + 1);
        end
    end

    task automatic set_req(input int m, input logic v, input logic we, input logic [3:0] a, input logic [15:0] d);
        if (m == 0) begin
            m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
        end else begin
            m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
        end
    endtask

    task automatic do_req(input int m, input logic we, input logic [3:0] a, input logic [15:0] d);
        int   t;
        logic rdy;
        t = 0;
        @(negedge clk);
        set_req(m, 1'b1, we, a, d);
        #1;
        rdy = (m == 0) ? m0_req_ready : m1_req_ready;
        while (!rdy && t < 100) begin
            @(negedge clk); #1;
            t++;
            rdy = (m == 0) ? m0_req_ready : m1_req_ready;
        end
        if (!rdy) begin
            nvec++; nerr++;
            $display("FAIL handshake_timeout m%0d: ready=0 required 1", m);
        end
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", q0.size() + q1.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int gbase;

    initial begin
        last0 = '0; last1 = '0;
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'h3, 16'h1234);
        set_req(1, 1'b1, 1'b0, 4'h4, 16'h5678);
        repeat (3) @(negedge clk);
        #2;
        chk("rst_m0_ready", m0_req_ready, 0);
        chk("rst_m1_ready", m1_req_ready, 0);
        chk("rst_m0_rsp_valid", m0_rsp_valid, 0);
        chk("rst_m1_rsp_valid", m1_rsp_valid, 0);
        chk("rst_m0_rdata", m0_rsp_rdata, 0);
        chk("rst_m1_rdata", m1_rsp_rdata, 0);
        chk("rst_cs", ram_cs, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_bus_driven", ram_we | (ram_cs & ram_oe & ~ram_we), 0);
        set_req(0, 1'b0, 1'b0, 4'h0, 16'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write then read on m0.
        do_req(0, 1'b1, 4'h3, 16'hBEEF);
        do_req(0, 1'b0, 4'h3, 16'h0);
        drain();
        chk("t2_m0_rdata", m0_rsp_rdata, 16'hBEEF);
        chk("t2_m1_rsp_count", rcnt1, 0);
        chk("t2_m0_rsp_count", rcnt0, 2);

        // m1 sweeps every address, including the 15 -> 0 wrap.
        for (int i = 0; i < 16; i++) swv[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) do_req(1, 1'b1, 4'(i), swv[i]);
        for (int i = 0; i < 16; i++) do_req(1, 1'b0, 4'(i), 16'h0);
        drain();
        chk("sweep_last_rdata", m1_rsp_rdata, swv[15]);

        // Contention: last grant was m1, so m0 leads.
        gbase = glog_m.size();
        fork
            begin
                for (int i = 0; i < 2; i++) do_req(0, 1'b1, 4'h0, 16'h1111 + 16'(i));
            end
            begin
                for (int i = 0; i < 2; i++) do_req(1, 1'b1, 4'h1, 16'h2222 + 16'(i));
            end
        join
        drain();
        for (int k = 0; k < 4; k++) chk("cont_grant_order", glog_m[gbase + k], k % 2);
        for (int k = 1; k < 4; k++) chk("cont_spacing", glog_e[gbase + k] - glog_e[gbase + k - 1], 2);
        do_req(0, 1'b0, 4'h0, 16'h0);
        do_req(1, 1'b0, 4'h1, 16'h0);
        drain();
        chk("cont_m0_readback", m0_rsp_rdata, 16'h1112);
        chk("cont_m1_readback", m1_rsp_rdata, 16'h2223);

        // m0 waits behind an m1 read and is granted right after the response edge.
        gbase = glog_m.size();
        fork
            do_req(1, 1'b0, 4'h5, 16'h0);
            begin
                @(negedge clk);
                do_req(0, 1'b0, 4'h1, 16'h0);
            end
        join
        drain();
        chk("ovl_first_grant", glog_m[gbase], 1);
        chk("ovl_second_grant", glog_m[gbase + 1], 0);
        chk("ovl_grant_gap", glog_e[gbase + 1] - glog_e[gbase], 3);
        chk("ovl_m1_rdata", m1_rsp_rdata, swv[5]);
        chk("ovl_m0_rdata", m0_rsp_rdata, 16'h2223);

        // Reset asserted during RD_CAP drops the read.
        do_req(0, 1'b0, 4'h2, 16'h0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0;
        #1;
        chk("mid_rst_cs", ram_cs, 0);
        chk("mid_rst_oe", ram_oe, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_m0_rdata", m0_rsp_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gbase = glog_m.size();
        fork
            do_req(0, 1'b1, 4'h7, 16'h7777);
            do_req(1, 1'b1, 4'h8, 16'h8888);
        join
        drain();
        chk("post_rst_first_grant", glog_m[gbase], 0);
        chk("post_rst_second_grant", glog_m[gbase + 1], 1);
        do_req(1, 1'b0, 4'h7, 16'h0);
        drain();
        chk("post_rst_readback", m1_rsp_rdata, 16'h7777);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-requester controller that shares one `single_port_sync_ram` instance (cs/we/oe control, bidirectional data bus) between independent masters. Each master issues read or write requests over a valid/ready handshake. A round-robin arbiter picks one request at a time. A small FSM sequences the RAM control pins and the tri-state bus. Read data and write completion return on a per-master response strobe.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width; depth is 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 16: RAM word width.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `m0_req_valid`, `m1_req_valid` in 1: request present.
- `m0_req_ready`, `m1_req_ready` out 1: request accepted this edge when high together with valid.
- `m0_req_we`, `m1_req_we` in 1: 1 = write, 0 = read.
- `m0_req_addr`, `m1_req_addr` in ADDR_WIDTH: target word.
- `m0_req_wdata`, `m1_req_wdata` in DATA_WIDTH: write data.
- `m0_rsp_valid`, `m1_rsp_valid` out 1: one-cycle completion pulse for a read or a write.
- `m0_rsp_rdata`, `m1_rsp_rdata` out DATA_WIDTH: read data, valid with rsp_valid for reads, held until the next read response to that master.
- `ram_cs`, `ram_we`, `ram_oe` out 1: RAM control pins.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_data` inout DATA_WIDTH: RAM data bus; the controller drives it only when `ram_we`=1, otherwise 'z.

## Operation
- States: IDLE, WR, RD, RD_CAP.
- **IDLE**
  - cs=we=oe=0; bus released.
  - If any valid is high, the arbiter grants exactly one master, and only the granted master's ready is high. Ready is combinational from the valids and the pointer, and is 0 outside IDLE.
  - On the handshake edge, latch we/addr/wdata and the grant index. Go to WR if we=1, else RD.
- **Round-robin**
  - A 1-bit `last` pointer records the most recent grant.
  - With both valids high, grant the master that is not `last`. With one valid high, grant that master.
  - `last` updates on every handshake. Reset value of `last` is 1, so m0 wins the first contention.
- **WR** (1 cycle)
  - cs=1, we=1, oe=0; drive `ram_data` with the latched wdata.
  - The RAM writes at the edge ending WR.
  - At that edge, pulse the granted master's rsp_valid and return to IDLE.
- **RD** (1 cycle)
  - cs=1, we=0, oe=1.
  - The RAM samples the address at the edge ending RD.
  - Go to RD_CAP.
- **RD_CAP** (1 cycle)
  - cs=1, we=0, oe=1; the RAM drives `ram_data`.
  - At the edge ending RD_CAP, register `ram_data` into the granted master's rsp_rdata, pulse its rsp_valid, and return to IDLE.
- **Address**
  - `ram_addr` = latched address in WR/RD/RD_CAP, 0 in IDLE.
- **Write responses**
  - rsp_rdata is not modified.
- **Reset**
  - Asynchronous; applies at any time, including mid-operation.
  - State=IDLE, cs=we=oe=0, bus 'z, ram_addr=0, both ready=0 (async reset dominates), both rsp_valid=0, both rsp_rdata=0, last=1.
  - An in-flight operation is dropped with no response.
- **Requester behaviour**
  - A requester whose valid drops before the handshake simply loses its turn.
  - Valid must not be dropped by the master after acceptance; there is no cancel.

## Timing
- Handshake at edge E0.
  - Write: rsp_valid high E1→E2; the RAM holds the data after E1.
  - Read: rsp_valid and rdata high E2→E3.
- Throughput:
  - Write occupies 2 cycles (IDLE + WR); read occupies 3 cycles.
  - Peak rate is one write every 2 cycles, or one read every 3 cycles.
- A new handshake can occur in the IDLE cycle that immediately follows a response edge, so the rsp_valid cycle may coincide with the next grant.
- The bus is never driven by both parties: the controller drives only when we=1, and the RAM drives only when cs&oe&!we.

## Structure
- Package `sp_ram_arb_pkg`: state encoding (IDLE=0, WR=1, RD=2, RD_CAP=3) and master index constants (M0=0, M1=1).
- Sub-module `rr_arbiter2`: two request inputs, two one-hot grant outputs, an `advance` input, and the `last` pointer register.
- The FSM, request latch, and response registers stay in the top module.

## Test plan
- **Reset state:** reset with both valids high → all outputs at their reset values, and the bus is 'z.
- **Single write then read:** m0 writes 0xBEEF to addr 3, then reads addr 3.
  - Write: m0_rsp_valid pulses 1 cycle after the handshake.
  - Read: m0_rsp_valid pulses 2 cycles after the handshake with m0_rsp_rdata=0xBEEF; m1 sees no pulses.
- **Contention:** both masters hold valid continuously, m0 writing addr 0 and m1 writing addr 1.
  - Grants alternate m0,m1,m0,m1, one handshake every 2 cycles.
  - Read-back gives each master its own data.
- **Full sweep:** m1 writes $random to all 16 addresses, then reads all 16 → each rdata matches the scoreboard; addr 15→0 covers the wrap.
- **Response/grant overlap:** m1 issues a read while m0 is waiting → m1_rsp_rdata is unaffected by the m0 grant that follows the response edge; m0's read returns correct data.
- **Reset mid-read:** assert rst_n low during RD_CAP.
  - No rsp_valid is produced; cs/oe drop asynchronously.
  - After release, m0 wins the first contention.
